// File: rtl/pc_sequencer.sv
// Multicycle FETCH/EXEC/HALTED sequencer for the MIPS core: owns the PC, drives
// instruction fetches and applies branch-delay-slot semantics to control transfers.
module pc_sequencer (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_address,
  output logic        mem_read,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        exec_stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic        in_delay_slot,
  output logic        active,
  output logic        fault
);

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_EXEC   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pending_target_q;
  logic        delay_pending_q;
  logic        fault_q;

  logic [31:0] pc_plus4;
  assign pc_plus4 = pc_q + 32'd4;

  // Sequencer state machine; a branch inside a delay slot is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_FETCH;
      pc_q             <= RESET_VECTOR;
      instr_q          <= 32'd0;
      pending_target_q <= 32'd0;
      delay_pending_q  <= 1'b0;
      fault_q          <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (!mem_waitrequest) begin
            instr_q <= mem_readdata;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!exec_stall) begin
            if (delay_pending_q) begin
              delay_pending_q <= 1'b0;
              if (pending_target_q[1:0] != 2'b00) begin
                fault_q <= 1'b1;
                state_q <= S_HALTED;
              end else begin
                pc_q    <= pending_target_q;
                state_q <= (pending_target_q == 32'd0) ? S_HALTED : S_FETCH;
              end
            end else if (branch_taken) begin
              pending_target_q <= branch_target;
              delay_pending_q  <= 1'b1;
              pc_q             <= pc_plus4;
              state_q          <= S_FETCH;
            end else begin
              pc_q    <= pc_plus4;
              state_q <= S_FETCH;
            end
          end
        end
        S_HALTED: begin
          state_q <= S_HALTED;
        end
        default: begin
          state_q <= S_FETCH;
        end
      endcase
    end
  end

  // Status outputs are masked while reset is asserted so the bus is quiet immediately.
  assign mem_address   = pc_q;
  assign pc            = pc_q;
  assign link_addr     = pc_q + 32'd8;
  assign instr         = instr_q;
  assign fault         = fault_q;
  assign mem_read      = !reset && (state_q == S_FETCH);
  assign instr_valid   = !reset && (state_q == S_EXEC);
  assign active        = reset || (state_q != S_HALTED);
  assign in_delay_slot = !reset && delay_pending_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multicycle instruction-sequencing controller for the MIPS core. It owns the program counter and the instruction-fetch side of the Avalon-style memory bus. It runs a FETCH/EXEC/HALTED state machine, applies MIPS branch-delay-slot semantics to branch and jump targets supplied by the datapath, and halts the core when control transfers to address 0. It sits between the memory interface and the decode/execute datapath and replaces free-running PC enable logic.

## Interface
- No parameters. Reset vector is fixed at 0xBFC00000.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_address  out  32  fetch address; always equal to pc.
- mem_read  out  1  fetch request; high only in FETCH and forced low while reset=1.
- mem_waitrequest  in  1  memory not ready; a read completes on a cycle with mem_read=1 and mem_waitrequest=0.
- mem_readdata  in  32  instruction word; valid on the completing cycle.
- instr  out  32  latched instruction word.
- instr_valid  out  1  high in every EXEC cycle.
- exec_stall  in  1  datapath needs another EXEC cycle; sampled only in EXEC.
- branch_taken  in  1  the current instruction transfers control; sampled on the EXEC completion cycle.
- branch_target  in  32  destination address; sampled together with branch_taken.
- pc  out  32  address of the instruction in fetch or execute.
- link_addr  out  32  pc+8, modulo 2^32, for link instructions.
- in_delay_slot  out  1  the current instruction is a delay slot.
- active  out  1  low only in HALTED.
- fault  out  1  sticky; set when the pending target is misaligned.

## Operation
- Reset values: state=FETCH, pc=0xBFC00000, instr=0, delay_pending=0, pending_target=0, fault=0. While reset=1: mem_read=0, instr_valid=0, active=1, in_delay_slot=0.
- FETCH state:
  - mem_read=1 and mem_address=pc, both held stable while mem_waitrequest=1.
  - On the first cycle with mem_waitrequest=0: instr<=mem_readdata, then go to EXEC.
- EXEC state:
  - instr_valid=1.
  - While exec_stall=1: stay in EXEC. pc, instr, pending state and branch inputs are all ignored or held.
  - The cycle with exec_stall=0 is the completion cycle. Exactly one of the following applies, in priority order:
  1. delay_pending=1, meaning the delay slot just finished. Clear delay_pending. If pending_target[1:0]≠0, set fault=1 and go to HALTED with pc unchanged. Otherwise pc<=pending_target. If pending_target=0, go to HALTED; otherwise go to FETCH. branch_taken is ignored in this case: a branch inside a delay slot is dropped.
  2. branch_taken=1: pending_target<=branch_target, delay_pending<=1, pc<=pc+4, go to FETCH.
  3. Otherwise: pc<=pc+4, go to FETCH.
- HALTED state:
  - mem_read=0, instr_valid=0, active=0.
  - All inputs are ignored; only reset leaves this state.
- in_delay_slot equals delay_pending.
- Arithmetic: pc+4 and pc+8 are computed at 32 bits with wrap-around, so 0xFFFFFFFC+4 gives 0x00000000. Sequential wrap to 0 does not halt; only a taken transfer to target 0 halts.

## Timing
- Minimum two cycles per instruction: one FETCH cycle with zero waitrequest, then one EXEC cycle.
- instr is valid from the cycle after read completion until the next read completes.
- A new pc is visible on mem_address in the cycle after the EXEC completion edge.
- After a taken branch, exactly one delay-slot instruction (branch address+4) is fetched and executed before the target is fetched.
- Halt: active falls in the cycle after the delay slot's completion edge. pc reads 0 (or the delay-slot pc if fault=1).
- Reset mid-fetch or mid-exec: the operation is abandoned. mem_read is low during reset, and the first cycle after reset re-fetches 0xBFC00000.

## Test plan
- Reset: hold reset 2 cycles, then release → that cycle shows mem_read=1, mem_address=0xBFC00000, active=1, fault=0, instr_valid=0.
- Wait states: hold waitrequest=1 for 3 cycles → mem_address stays at 0xBFC00000 throughout. Data 0x24020005 is captured on the 4th cycle, and the next cycle shows instr_valid=1, instr=0x24020005.
- Sequential and stall: three non-branch instructions, with exec_stall=1 for 4 cycles on the second → fetch addresses 0xBFC00000, 0xBFC00004, 0xBFC00008. pc is held during the stall and link_addr=pc+8.
- Delay slot: branch_taken=1, target 0xBFC00100 at 0xBFC00000 → next fetch 0xBFC00004 with in_delay_slot=1. A branch_taken=1 inside the slot is ignored. The following fetch is 0xBFC00100 with in_delay_slot=0.
- Halt: jump to target 0 from 0xBFC00010 → the slot at 0xBFC00014 executes, then active=0, pc=0, mem_read=0 for 20+ cycles; a reset restarts at 0xBFC00000.
- Fault and wrap: target 0xBFC00102 → after the slot, fault=1 and active=0. Separately, sequential execution from 0xFFFFFFFC → the next fetch is 0x00000000 with active=1.
